// File: rtl/spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_arbiter
// Purpose  : Shares one SPI NOR flash (standard 0x03 READ, mode 0) between
//            the instruction-fetch and data-read ports. Requests are
//            round-robin arbitrated; each grant runs one complete
//            transaction (8-bit command, 24-bit address, 32 data bits) and
//            returns a little-endian word with a one-cycle ready pulse.
// Ports    : clk, n_reset           - clock, async active-low reset
//            ifetch_valid/addr      - fetch request and byte address
//            ifetch_ready/rdata     - fetch completion pulse and read data
//            data_valid/addr        - data request and byte address
//            data_ready/rdata       - data completion pulse and read data
//            spi_cs/clk/mosi/miso   - flash pads (cs active low)
//            busy                   - high from grant until end of CS gap
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_arbiter #(
  parameter int unsigned CLK_DIV        = 2,  // clk cycles per spi_clk half-period
  parameter int unsigned SPI_FLASH_BASE = 0,  // offset added to request address
  parameter int unsigned CS_IDLE_CYCLES = 2   // min cs-high cycles between transfers
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        ifetch_valid,
  input  logic [23:0] ifetch_addr,
  output logic        ifetch_ready,
  output logic [31:0] ifetch_rdata,
  input  logic        data_valid,
  input  logic [23:0] data_addr,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'(CS_IDLE_CYCLES - 1);
  localparam logic [23:0]      c_BASE24   = SPI_FLASH_BASE[23:0];
  localparam logic [7:0]       c_CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;          // 0 = ifetch, 1 = data
  logic             last_grant_q, last_grant_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             high_q, high_d;            // current half-bit is the high phase
  logic [5:0]       bit_q, bit_d;              // 0..63 across cmd/addr/data
  logic [31:0]      tx_q, tx_d;                // remaining command+address bits, MSB next
  logic [31:0]      rx_q, rx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             spi_cs_q, spi_cs_d;
  logic             spi_clk_q, spi_clk_d;
  logic             spi_mosi_q, spi_mosi_d;
  logic             busy_q, busy_d;
  logic             ifetch_ready_q, ifetch_ready_d;
  logic             data_ready_q, data_ready_d;
  logic [31:0]      ifetch_rdata_q, ifetch_rdata_d;
  logic [31:0]      data_rdata_q, data_rdata_d;

  logic             w_pick_data;
  logic [23:0]      w_req_addr;
  logic [23:0]      w_sum;
  logic [31:0]      w_tx_init;
  logic [31:0]      w_rdata_le;

  // Round robin: on a tie the port that was not served last wins.
  always_comb begin
    w_pick_data = data_valid & (~ifetch_valid | ~last_grant_q);
    w_req_addr  = w_pick_data ? data_addr : ifetch_addr;
    w_sum       = w_req_addr + c_BASE24;
    w_tx_init   = {c_CMD_READ, w_sum[23:2], 2'b00};
    // First received byte sits in rx_q[31:24]; it belongs in rdata[7:0].
    w_rdata_le  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    div_d          = div_q;
    high_d         = high_q;
    bit_d          = bit_q;
    tx_d           = tx_q;
    rx_d           = rx_q;
    gap_d          = gap_q;
    spi_cs_d       = spi_cs_q;
    spi_clk_d      = spi_clk_q;
    spi_mosi_d     = spi_mosi_q;
    busy_d         = busy_q;
    ifetch_ready_d = 1'b0;
    data_ready_d   = 1'b0;
    ifetch_rdata_d = ifetch_rdata_q;
    data_rdata_d   = data_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ifetch_valid || data_valid) begin
          grant_d    = w_pick_data;
          tx_d       = w_tx_init;
          spi_mosi_d = w_tx_init[31];
          spi_cs_d   = 1'b0;
          spi_clk_d  = 1'b0;
          busy_d     = 1'b1;
          div_d      = '0;
          high_d     = 1'b0;
          bit_d      = 6'd0;
          state_d    = ST_CMD;
        end
      end

      ST_CMD, ST_ADDR, ST_DATA: begin
        if (div_q == c_DIV_LAST) begin
          div_d = '0;
          if (!high_q) begin
            // Rising spi_clk: flash data is stable, capture it now.
            high_d    = 1'b1;
            spi_clk_d = 1'b1;
            if (state_q == ST_DATA) begin
              rx_d = {rx_q[30:0], spi_miso};
            end
          end else begin
            high_d    = 1'b0;
            spi_clk_d = 1'b0;
            if (bit_q == 6'd63) begin
              spi_cs_d     = 1'b1;
              spi_mosi_d   = 1'b0;
              gap_d        = '0;
              last_grant_d = grant_q;
              state_d      = ST_GAP;
              if (grant_q) begin
                data_ready_d = 1'b1;
                data_rdata_d = w_rdata_le;
              end else begin
                ifetch_ready_d = 1'b1;
                ifetch_rdata_d = w_rdata_le;
              end
            end else begin
              // Falling spi_clk: present the next bit for the whole low phase.
              bit_d      = bit_q + 6'd1;
              tx_d       = {tx_q[30:0], 1'b0};
              spi_mosi_d = tx_q[30];
              if (bit_q == 6'd7) begin
                state_d = ST_ADDR;
              end else if (bit_q == 6'd31) begin
                state_d = ST_DATA;
              end
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_q == c_GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;  // so ifetch wins the first tie
      div_q          <= '0;
      high_q         <= 1'b0;
      bit_q          <= 6'd0;
      tx_q           <= 32'd0;
      rx_q           <= 32'd0;
      gap_q          <= '0;
      spi_cs_q       <= 1'b1;
      spi_clk_q      <= 1'b0;
      spi_mosi_q     <= 1'b0;
      busy_q         <= 1'b0;
      ifetch_ready_q <= 1'b0;
      data_ready_q   <= 1'b0;
      ifetch_rdata_q <= 32'd0;
      data_rdata_q   <= 32'd0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      div_q          <= div_d;
      high_q         <= high_d;
      bit_q          <= bit_d;
      tx_q           <= tx_d;
      rx_q           <= rx_d;
      gap_q          <= gap_d;
      spi_cs_q       <= spi_cs_d;
      spi_clk_q      <= spi_clk_d;
      spi_mosi_q     <= spi_mosi_d;
      busy_q         <= busy_d;
      ifetch_ready_q <= ifetch_ready_d;
      data_ready_q   <= data_ready_d;
      ifetch_rdata_q <= ifetch_rdata_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign spi_cs       = spi_cs_q;
  assign spi_clk      = spi_clk_q;
  assign spi_mosi     = spi_mosi_q;
  assign busy         = busy_q;
  assign ifetch_ready = ifetch_ready_q;
  assign data_ready   = data_ready_q;
  assign ifetch_rdata = ifetch_rdata_q;
  assign data_rdata   = data_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_arbiter
// Purpose  : Self-checking bench for spi_flash_arbiter. Three instances:
//            0: CLK_DIV=2, base 0; 1: CLK_DIV=1, base 0x100000; 2: CLK_DIV=4.
//            A behavioural flash per instance decodes cmd/address and drives
//            miso; expected responses are queued at issue and popped by a
//            monitor whenever a ready pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_arbiter;

  localparam int N = 3;
  localparam int CS_IDLE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset      [N];
  logic        ifetch_valid [N];
  logic [23:0] ifetch_addr  [N];
  logic        data_valid   [N];
  logic [23:0] data_addr    [N];
  logic        spi_miso     [N];
  wire         ifetch_ready [N];
  wire  [31:0] ifetch_rdata [N];
  wire         data_ready   [N];
  wire  [31:0] data_rdata   [N];
  wire         spi_cs       [N];
  wire         spi_clk      [N];
  wire         spi_mosi     [N];
  wire         busy         [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_flash_arbiter #(
      .CLK_DIV       ((g == 1) ? 1 : ((g == 2) ? 4 : 2)),
      .SPI_FLASH_BASE((g == 1) ? 32'h0010_0000 : 32'h0),
      .CS_IDLE_CYCLES(CS_IDLE)
    ) u_dut (
      .clk         (clk),
      .n_reset     (n_reset[g]),
      .ifetch_valid(ifetch_valid[g]),
      .ifetch_addr (ifetch_addr[g]),
      .ifetch_ready(ifetch_ready[g]),
      .ifetch_rdata(ifetch_rdata[g]),
      .data_valid  (data_valid[g]),
      .data_addr   (data_addr[g]),
      .data_ready  (data_ready[g]),
      .data_rdata  (data_rdata[g]),
      .spi_cs      (spi_cs[g]),
      .spi_clk     (spi_clk[g]),
      .spi_mosi    (spi_mosi[g]),
      .spi_miso    (spi_miso[g]),
      .busy        (busy[g])
    );
  end

  typedef struct {
    int          inst;
    bit          port;     // 0 = ifetch, 1 = data
    logic [23:0] faddr;    // address the flash must see
    logic [31:0] data;
    int          exp_cyc;  // -1 = latency not checked
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt  [N];
  int bitn      [N];
  int last_rise [N];
  int hi_cnt    [N];
  bit seen_txn  [N];
  logic [31:0] sh      [N];
  logic [7:0]  fl_cmd  [N];
  logic [23:0] fl_addr [N];
  logic prev_clk [N];
  logic prev_cs  [N];
  logic prev_mosi[N];

  function automatic int cd_of(int i);
    return (i == 1) ? 1 : ((i == 2) ? 4 : 2);
  endfunction

  // Flash contents: a few hand-placed bytes, a scrambled pattern elsewhere.
  function automatic logic [7:0] flash_byte(logic [23:0] a);
    case (a)
      24'h000100: return 8'h13;
      24'h000101: return 8'h05;
      24'h000102: return 8'h00;
      24'h000103: return 8'h00;
      default:    return (a[7:0] * 8'd7) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] flash_word(logic [23:0] a);
    return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
  endfunction

  task automatic chk(bit ok, string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(int i, bit port, logic [23:0] fa, logic [31:0] d, int ec);
    exp_t e;
    e.inst = i; e.port = port; e.faddr = fa; e.data = d; e.exp_cyc = ec;
    sb.push_back(e);
  endtask

  task automatic wait_done(int i, int target, int budget, string name);
    int n = 0;
    while (done_cnt[i] < target && n < budget) begin
      tick(1);
      n++;
    end
    chk(done_cnt[i] >= target, name, 32'(done_cnt[i]), 32'(target));
  endtask

  // Flash model, pad-timing checks and scoreboard consumer, once per cycle.
  task automatic monitor_loop();
    exp_t        e;
    int          k;
    logic [7:0]  bv;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (spi_cs[i]) begin
          bitn[i] = 0;
          hi_cnt[i]++;
        end else begin
          if (prev_cs[i]) begin
            if (seen_txn[i]) chk(hi_cnt[i] >= CS_IDLE, "cs_gap", 32'(hi_cnt[i]), 32'(CS_IDLE));
            seen_txn[i] = 1'b1;
            hi_cnt[i]   = 0;
          end
          if (spi_clk[i] && !prev_clk[i]) begin
            chk(spi_mosi[i] == prev_mosi[i], "mosi_stable", 32'(spi_mosi[i]), 32'(prev_mosi[i]));
            if (bitn[i] > 0)
              chk(cyc - last_rise[i] == 2 * cd_of(i), "sclk_period",
                  32'(cyc - last_rise[i]), 32'(2 * cd_of(i)));
            last_rise[i] = cyc;
            if (bitn[i] < 32) sh[i] = {sh[i][30:0], spi_mosi[i]};
            bitn[i]++;
            if (bitn[i] == 32) begin
              fl_cmd[i]  = sh[i][31:24];
              fl_addr[i] = sh[i][23:0];
            end
          end
          if (!spi_clk[i] && prev_clk[i] && bitn[i] >= 32 && bitn[i] < 64) begin
            k  = bitn[i] - 32;
            bv = flash_byte(fl_addr[i] + 24'(k / 8));
            spi_miso[i] = bv[3'(7 - k % 8)];
          end
        end

        if (ifetch_ready[i] || data_ready[i]) begin
          chk(!(ifetch_ready[i] && data_ready[i]), "single_ready",
              {30'd0, data_ready[i], ifetch_ready[i]}, 32'd0);
          chk(sb.size() != 0, "ready_expected", 32'(i), 32'(sb.size()));
          if (sb.size() != 0) begin
            e   = sb.pop_front();
            got = e.port ? data_rdata[i] : ifetch_rdata[i];
            chk(e.inst == i, "sb_inst", 32'(i), 32'(e.inst));
            chk(data_ready[i] == e.port, "ready_port", 32'(data_ready[i]), 32'(e.port));
            chk(got == e.data, e.port ? "data_rdata" : "ifetch_rdata", got, e.data);
            chk(fl_cmd[i] == 8'h03, "cmd_byte", 32'(fl_cmd[i]), 32'h03);
            chk(fl_addr[i] == e.faddr, "addr_bytes", 32'(fl_addr[i]), 32'(e.faddr));
            if (e.exp_cyc >= 0)
              chk(cyc == e.exp_cyc, "ready_latency", 32'(cyc), 32'(e.exp_cyc));
          end
          done_cnt[i]++;
        end
        prev_clk[i]  = spi_clk[i];
        prev_cs[i]   = spi_cs[i];
        prev_mosi[i] = spi_mosi[i];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      n_reset[i] = 1'b0; ifetch_valid[i] = 1'b0; data_valid[i] = 1'b0;
      ifetch_addr[i] = 24'd0; data_addr[i] = 24'd0; spi_miso[i] = 1'b0;
      done_cnt[i] = 0; bitn[i] = 0; last_rise[i] = 0; hi_cnt[i] = 0; seen_txn[i] = 1'b0;
      sh[i] = 32'd0; fl_cmd[i] = 8'd0; fl_addr[i] = 24'd0;
      prev_clk[i] = 1'b0; prev_cs[i] = 1'b1; prev_mosi[i] = 1'b0;
    end
    fork
      monitor_loop();
    join_none

    // Reset values
    tick(3);
    for (int i = 0; i < N; i++) begin
      chk(spi_cs[i] == 1'b1, "rst_cs", 32'(spi_cs[i]), 32'd1);
      chk(spi_clk[i] == 1'b0, "rst_sclk", 32'(spi_clk[i]), 32'd0);
      chk(spi_mosi[i] == 1'b0, "rst_mosi", 32'(spi_mosi[i]), 32'd0);
      chk(busy[i] == 1'b0, "rst_busy", 32'(busy[i]), 32'd0);
      chk(ifetch_ready[i] == 1'b0, "rst_iready", 32'(ifetch_ready[i]), 32'd0);
      chk(data_ready[i] == 1'b0, "rst_dready", 32'(data_ready[i]), 32'd0);
      chk(ifetch_rdata[i] == 32'd0, "rst_irdata", ifetch_rdata[i], 32'd0);
      chk(data_rdata[i] == 32'd0, "rst_drdata", data_rdata[i], 32'd0);
      n_reset[i] = 1'b1;
    end
    tick(2);

    // Single fetch of 0x000100: flash bytes 13 05 00 00 -> 0x00000513
    ifetch_addr[0] = 24'h000100; ifetch_valid[0] = 1'b1;
    push(0, 1'b0, 24'h000100, 32'h0000_0513, cyc + 1 + 256);
    tick(1);
    ifetch_valid[0] = 1'b0;
    chk(spi_cs[0] == 1'b0, "grant_cs_low", 32'(spi_cs[0]), 32'd0);
    chk(busy[0] == 1'b1, "grant_busy", 32'(busy[0]), 32'd1);
    wait_done(0, 1, 400, "t1_timeout");
    tick(1);
    chk(data_rdata[0] == 32'd0, "data_rdata_untouched", data_rdata[0], 32'd0);
    tick(4);

    // Unaligned fetch 0x000103 reads the word at 0x000100
    ifetch_addr[0] = 24'h000103; ifetch_valid[0] = 1'b1;
    push(0, 1'b0, 24'h000100, 32'h0000_0513, cyc + 1 + 256);
    tick(1);
    ifetch_valid[0] = 1'b0;
    wait_done(0, 2, 400, "t2_timeout");
    tick(4);

    // Both requesters held from reset: grants alternate I, D, I, D
    n_reset[0] = 1'b0;
    ifetch_addr[0] = 24'h000200; data_addr[0] = 24'h001000;
    ifetch_valid[0] = 1'b1; data_valid[0] = 1'b1;
    tick(2);
    n_reset[0] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      push(0, 1'b0, 24'h000200, flash_word(24'h000200), -1);
      push(0, 1'b1, 24'h001000, flash_word(24'h001000), -1);
    end
    wait_done(0, 6, 1400, "rr_timeout");
    ifetch_valid[0] = 1'b0; data_valid[0] = 1'b0;
    tick(6);

    // Reset during the address phase aborts without a ready pulse
    ifetch_addr[0] = 24'h000400; ifetch_valid[0] = 1'b1;
    tick(1);
    ifetch_valid[0] = 1'b0;
    tick(70);
    chk(spi_cs[0] == 1'b0, "addr_phase_cs", 32'(spi_cs[0]), 32'd0);
    chk(busy[0] == 1'b1, "addr_phase_busy", 32'(busy[0]), 32'd1);
    n_reset[0] = 1'b0;
    #1;
    chk(spi_cs[0] == 1'b1, "abort_cs", 32'(spi_cs[0]), 32'd1);
    chk(spi_clk[0] == 1'b0, "abort_sclk", 32'(spi_clk[0]), 32'd0);
    chk(busy[0] == 1'b0, "abort_busy", 32'(busy[0]), 32'd0);
    chk(ifetch_rdata[0] == 32'd0, "abort_irdata", ifetch_rdata[0], 32'd0);
    tick(3);
    n_reset[0] = 1'b1;
    tick(2);
    ifetch_addr[0] = 24'h000000; ifetch_valid[0] = 1'b1;
    push(0, 1'b0, 24'h000000, flash_word(24'h000000), cyc + 1 + 256);
    tick(1);
    ifetch_valid[0] = 1'b0;
    wait_done(0, 7, 400, "post_reset_timeout");
    tick(4);

    // Data requester drops valid mid-transfer; pending fetch follows
    data_addr[0] = 24'h002000; data_valid[0] = 1'b1;
    push(0, 1'b1, 24'h002000, flash_word(24'h002000), cyc + 1 + 256);
    tick(10);
    data_valid[0] = 1'b0;
    ifetch_addr[0] = 24'h000300; ifetch_valid[0] = 1'b1;
    push(0, 1'b0, 24'h000300, flash_word(24'h000300), -1);
    wait_done(0, 8, 400, "drop_d_timeout");
    wait_done(0, 9, 400, "pend_i_timeout");
    ifetch_valid[0] = 1'b0;
    tick(300);
    chk(done_cnt[0] == 9, "no_extra_txn", 32'(done_cnt[0]), 32'd9);

    // CLK_DIV=1, base 0x100000: 0xFFFFF0 wraps to 0x0FFFF0, ready at T+129
    data_addr[1] = 24'hFFFFF0; data_valid[1] = 1'b1;
    push(1, 1'b1, 24'h0FFFF0, flash_word(24'h0FFFF0), cyc + 1 + 128);
    tick(1);
    data_valid[1] = 1'b0;
    wait_done(1, 1, 300, "div1_timeout");
    tick(4);

    // CLK_DIV=4: ready at T+513
    ifetch_addr[2] = 24'h000100; ifetch_valid[2] = 1'b1;
    push(2, 1'b0, 24'h000100, 32'h0000_0513, cyc + 1 + 512);
    tick(1);
    ifetch_valid[2] = 1'b0;
    wait_done(2, 1, 800, "div4_timeout");
    tick(4);

    chk(sb.size() == 0, "sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
